// File: rtl/adder_arb_pkg.sv
// Shared types for the adder-sharing arbiter.
// Optional overflow flag output: define ARB_OVF_FLAG_EN.
package adder_arb_pkg;

  localparam int ADD_W = 9;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    logic             cin;
    logic             last;
  } add_req_t;

endpackage

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo N; one-hot grant plus encoded id.
module rr_pick #(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_oh_o,
  output logic [ID_W-1:0] gnt_id_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_oh_o = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % N);
      if (!found && valid_i[idx]) begin
        found         = 1'b1;
        gnt_id_o      = idx;
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter_select_adder.sv
// 9-bit carry-select adder: ripple low nibble, upper bits
// precomputed for both carries and selected by the nibble carry.
module select_adder
  import adder_arb_pkg::*;
(
  input  logic [ADD_W-1:0] a_i,
  input  logic [ADD_W-1:0] b_i,
  input  logic             cin_i,
  output logic [ADD_W-1:0] s_o,
  output logic             cout_o
);

  localparam int LO = 4;
  localparam int HI = ADD_W - LO;

  logic [LO:0] lo;
  logic [HI:0] hi0;
  logic [HI:0] hi1;

  assign lo  = {1'b0, a_i[LO-1:0]} + {1'b0, b_i[LO-1:0]}
             + {{LO{1'b0}}, cin_i};
  assign hi0 = {1'b0, a_i[ADD_W-1:LO]} + {1'b0, b_i[ADD_W-1:LO]};
  assign hi1 = {1'b0, a_i[ADD_W-1:LO]} + {1'b0, b_i[ADD_W-1:LO]}
             + {{HI{1'b0}}, 1'b1};

  assign {cout_o, s_o} = lo[LO] ? {hi1, lo[LO-1:0]}
                                : {hi0, lo[LO-1:0]};

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one carry-select adder with chained beats.
// Optional signed-overflow output rsp_ovf: define ARB_OVF_FLAG_EN.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0][ADD_W-1:0]  req_A,
  input  logic [N_REQ-1:0][ADD_W-1:0]  req_B,
  input  logic [N_REQ-1:0]             req_cin,
  input  logic [N_REQ-1:0]             req_last,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ADD_W-1:0]             rsp_S,
  output logic                         rsp_cout,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         rsp_last
`ifdef ARB_OVF_FLAG_EN
  ,
  output logic                         rsp_ovf
`endif
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic            carry_q, carry_d;

  logic             rsp_valid_q;
  logic [ADD_W-1:0] rsp_S_q;
  logic             rsp_cout_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             rsp_last_q;

  logic [N_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  sel_id;
  add_req_t         sel;
  logic             add_cin;
  logic [ADD_W-1:0] sum;
  logic             cout;
  logic             slot_free;
  logic             accept;

  function automatic logic [ID_W-1:0] ptr_inc(
    input logic [ID_W-1:0] id
  );
    if (int'(id) == N_REQ - 1) return '0;
    return id + 1'b1;
  endfunction

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .valid_i  (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_oh_o (gnt_oh),
    .gnt_id_o (gnt_id)
  );

  assign slot_free = !rsp_valid_q | rsp_ready;
  assign sel_id    = (state_q == ARB_LOCKED) ? owner_q : gnt_id;
  assign sel       = '{a:    req_A[sel_id],
                       b:    req_B[sel_id],
                       cin:  req_cin[sel_id],
                       last: req_last[sel_id]};
  // Chain beats take the held carry; requester cin only opens a chain
  assign add_cin   = (state_q == ARB_LOCKED) ? carry_q : sel.cin;
  assign accept    = |(req_valid & req_ready);

  select_adder u_select_adder (
    .a_i    (sel.a),
    .b_i    (sel.b),
    .cin_i  (add_cin),
    .s_o    (sum),
    .cout_o (cout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      carry_q  <= carry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    carry_d  = carry_q;
    if (accept) begin
      if (sel.last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = ptr_inc(sel_id);
        carry_d  = 1'b0;
      end else begin
        state_d  = ARB_LOCKED;
        owner_d  = sel_id;
        carry_d  = cout;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!Reset && slot_free) begin
      unique case (state_q)
        ARB_IDLE:   req_ready = gnt_oh;
        ARB_LOCKED: req_ready[owner_q] = 1'b1;
        default:    req_ready = '0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid_q <= 1'b0;
      rsp_S_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_last_q  <= 1'b0;
    end else if (slot_free) begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_S_q    <= sum;
        rsp_cout_q <= cout;
        rsp_id_q   <= sel_id;
        rsp_last_q <= sel.last;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_S     = rsp_S_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_last  = rsp_last_q;

`ifdef ARB_OVF_FLAG_EN
  logic rsp_ovf_q;
  logic ovf;

  assign ovf = (sel.a[ADD_W-1] == sel.b[ADD_W-1])
             & (sum[ADD_W-1] != sel.a[ADD_W-1]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_ovf_q <= 1'b0;
    end else if (slot_free && accept) begin
      rsp_ovf_q <= ovf;
    end
  end

  assign rsp_ovf = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with an arithmetic
// reference model checked every cycle on the falling edge.
module tb_adder_share_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;

  logic               Clk = 1'b0;
  logic               Reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][8:0]  req_A;
  logic [N-1:0][8:0]  req_B;
  logic [N-1:0]       req_cin;
  logic [N-1:0]       req_last;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [8:0]         rsp_S;
  logic               rsp_cout;
  logic [IW-1:0]      rsp_id;
  logic               rsp_last;
`ifdef ARB_OVF_FLAG_EN
  logic               rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  adder_share_arbiter #(.N_REQ(N)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_A     (req_A),
    .req_B     (req_B),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_S     (rsp_S),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last)
`ifdef ARB_OVF_FLAG_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: owner/pointer/carry plus the registered result
  bit         m_valid = 0;
  logic [8:0] m_S = '0;
  bit         m_cout = 0, m_last = 0, m_ovf = 0;
  int         m_id = 0, m_ptr = 0, m_owner = 0;
  bit         m_locked = 0, m_carry = 0;

  function automatic int pick();
    int idx;
    if (m_locked) return m_owner;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[IW'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (Reset || !(!m_valid || rsp_ready)) return r;
    g = pick();
    if (g >= 0) r[IW'(g)] = 1'b1;
    return r;
  endfunction

  int   g_m;
  bit   cin_m;
  int   tot_m;
  logic [8:0] a_m, b_m;

  always @(posedge Clk) begin
    if (Reset) begin
      m_valid = 0; m_S = '0; m_cout = 0; m_last = 0; m_ovf = 0;
      m_id = 0; m_ptr = 0; m_owner = 0; m_locked = 0; m_carry = 0;
    end else if (!m_valid || rsp_ready) begin
      g_m = pick();
      if (g_m >= 0 && req_valid[IW'(g_m)]) begin
        a_m    = req_A[IW'(g_m)];
        b_m    = req_B[IW'(g_m)];
        cin_m  = m_locked ? m_carry : req_cin[IW'(g_m)];
        tot_m  = int'(a_m) + int'(b_m) + int'(cin_m);
        m_S    = tot_m[8:0];
        m_cout = tot_m[9];
        m_ovf  = (a_m[8] == b_m[8]) && (m_S[8] != a_m[8]);
        m_id   = g_m;
        m_last = req_last[IW'(g_m)];
        m_valid = 1;
        if (m_last) begin
          m_locked = 0; m_ptr = (g_m + 1) % N; m_carry = 0;
        end else begin
          m_locked = 1; m_owner = g_m; m_carry = m_cout;
        end
      end else begin
        m_valid = 0;
      end
    end
  end

  always @(negedge Clk) begin
    chk("m_ready", 16'(req_ready), 16'(exp_ready()));
    chk("m_valid", 16'(rsp_valid), 16'(m_valid));
    if (m_valid) begin
      chk("m_S", 16'(rsp_S), 16'(m_S));
      chk("m_cout", 16'(rsp_cout), 16'(m_cout));
      chk("m_id", 16'(rsp_id), 16'(m_id));
      chk("m_last", 16'(rsp_last), 16'(m_last));
`ifdef ARB_OVF_FLAG_EN
      chk("m_ovf", 16'(rsp_ovf), 16'(m_ovf));
`endif
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic rsp(input string nm, input logic [8:0] s,
                     input logic c, input int id, input logic l);
    chk({nm, "_valid"}, 16'(rsp_valid), 16'd1);
    chk({nm, "_S"}, 16'(rsp_S), 16'(s));
    chk({nm, "_cout"}, 16'(rsp_cout), 16'(c));
    chk({nm, "_id"}, 16'(rsp_id), 16'(id));
    chk({nm, "_last"}, 16'(rsp_last), 16'(l));
  endtask

  initial begin
    Reset = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_A = '0; req_B = '0; req_cin = '0; req_last = '0;

    // 1: reset state then single beat
    req_valid = 2'b01;
    req_A[0] = 9'h0FF; req_B[0] = 9'h001;
    req_cin[0] = 1'b0; req_last[0] = 1'b1;
    tick(); tick();
    chk("rst_valid", 16'(rsp_valid), 16'd0);
    chk("rst_S", 16'(rsp_S), 16'd0);
    chk("rst_cout", 16'(rsp_cout), 16'd0);
    chk("rst_id", 16'(rsp_id), 16'd0);
    chk("rst_ready", 16'(req_ready), 16'd0);
    Reset = 1'b0;
    #1 chk("t1_ready", 16'(req_ready), 16'b01);
    tick();
    rsp("t1", 9'h100, 1'b0, 0, 1'b1);
`ifdef ARB_OVF_FLAG_EN
    chk("t6_ovf1", 16'(rsp_ovf), 16'd1);
`endif
    req_A[0] = 9'h1FF; req_B[0] = 9'h001;
    tick();
    rsp("t1b", 9'h000, 1'b1, 0, 1'b1);
`ifdef ARB_OVF_FLAG_EN
    chk("t6_ovf0", 16'(rsp_ovf), 16'd0);
`endif

    // 2: two requesters alternate without bubbles
    do_reset();
    req_valid = 2'b11;
    req_A[0] = 9'h001; req_B[0] = 9'h002; req_cin[0] = 0; req_last[0] = 1;
    req_A[1] = 9'h003; req_B[1] = 9'h004; req_cin[1] = 0; req_last[1] = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      rsp("t2", (i % 2) ? 9'h007 : 9'h003, 1'b0, i % 2, 1'b1);
    end

    // 3: three-beat chain on requester 1, requester 0 stalled
    req_valid = 2'b10;
    req_A[1] = 9'h1FF; req_B[1] = 9'h001; req_cin[1] = 1; req_last[1] = 0;
    req_A[0] = 9'h005; req_B[0] = 9'h006; req_cin[0] = 0; req_last[0] = 1;
    tick();
    rsp("t3b1", 9'h001, 1'b1, 1, 1'b0);
    req_valid = 2'b11;
    req_A[1] = 9'h000; req_B[1] = 9'h000; req_cin[1] = 1; req_last[1] = 0;
    #1 chk("t3_lock1", 16'(req_ready), 16'b10);
    tick();
    rsp("t3b2", 9'h001, 1'b0, 1, 1'b0);
    req_A[1] = 9'h100; req_B[1] = 9'h100; req_cin[1] = 1; req_last[1] = 1;
    #1 chk("t3_lock2", 16'(req_ready), 16'b10);
    tick();
    rsp("t3b3", 9'h000, 1'b1, 1, 1'b1);
    req_valid = 2'b01;
    tick();
    rsp("t3r0", 9'h00B, 1'b0, 0, 1'b1);

    // 4: back-pressure holds the result, release accepts same cycle
    req_valid = '0;
    tick();
    req_valid = 2'b01;
    req_A[0] = 9'h050; req_B[0] = 9'h005; req_cin[0] = 0; req_last[0] = 1;
    rsp_ready = 1'b0;
    tick();
    rsp("t4", 9'h055, 1'b0, 0, 1'b1);
    req_valid = 2'b10;
    req_A[1] = 9'h010; req_B[1] = 9'h001; req_cin[1] = 0; req_last[1] = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_bp_ready", 16'(req_ready), 16'd0);
      tick();
      rsp("t4_hold", 9'h055, 1'b0, 0, 1'b1);
    end
    rsp_ready = 1'b1;
    #1 chk("t4_rel_ready", 16'(req_ready), 16'b10);
    tick();
    rsp("t4_rel", 9'h011, 1'b0, 1, 1'b1);

    // 5: reset mid-chain abandons chain and pointer
    req_valid = 2'b01;
    req_A[0] = 9'h1FF; req_B[0] = 9'h001; req_cin[0] = 0; req_last[0] = 0;
    tick();
    rsp("t5b1", 9'h000, 1'b1, 0, 1'b0);
    req_A[0] = 9'h002; req_B[0] = 9'h003; req_last[0] = 1;
    Reset = 1'b1;
    tick();
    chk("t5_rst_valid", 16'(rsp_valid), 16'd0);
    Reset = 1'b0;
    req_valid = 2'b11;
    req_A[0] = 9'h001; req_B[0] = 9'h001; req_cin[0] = 1; req_last[0] = 1;
    req_A[1] = 9'h007; req_B[1] = 9'h007; req_cin[1] = 0; req_last[1] = 1;
    #1 chk("t5_ready", 16'(req_ready), 16'b01);
    tick();
    rsp("t5", 9'h003, 1'b0, 0, 1'b1);

    req_valid = '0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
